// File: rtl/rs232_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the 8N1 oversampling serial receiver:
// state encoding, oversampling geometry and the baud divider helper.
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Three sample points around the middle of each bit cell; the middle
  // one also serves as the start-bit glitch check.
  localparam int SAMPLE_EARLY = 7;
  localparam int SAMPLE_MID   = 8;
  localparam int SAMPLE_LATE  = 9;

  // Clocks per oversample tick, integer truncation.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

  // Majority of three samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_rx_if.sv
`timescale 1ns/1ps
// Consumer-side bundle of the receiver: byte holding register with a
// valid/ready handshake plus status flags.
interface rs232_rx_if;
  import rs232_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data, valid, frame_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, overrun, busy,
    output ready
  );
endinterface

// File: rtl/rs232_baud_tick.sv
`timescale 1ns/1ps
// Oversample tick generator: one-cycle tick every DIV clocks, with a
// synchronous clear so a bit period can be re-phased to a line edge.
module rs232_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  // Free-running divider, wraps after LAST or when cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // A clear cycle never produces a tick, so the first tick after
  // re-phasing lands a full DIV clocks later.
  assign tick = (cnt_reg == LAST) && !clear;

endmodule

// File: rtl/rs232_rx.sv
`timescale 1ns/1ps
// 8N1 serial receiver, LSB first, 16x oversampling with 3-sample majority
// voting. The oversample counter is zeroed on the start edge and keeps
// running through the frame, so os=0 marks each bit boundary and samples
// 7/8/9 straddle the middle of every cell.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  rs232_rx_if.master  bus
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [3:0]    OS_EARLY = 4'(SAMPLE_EARLY);
  localparam logic [3:0]    OS_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0]    OS_LATE  = 4'(SAMPLE_LATE);
  localparam logic [3:0]    OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  // Synchronizer and edge detection
  logic [1:0] sync_reg;
  logic       rx_s;
  logic       rx_s_prev_reg;
  logic       fall;

  // FSM and datapath state
  rx_state_t            state_reg, state_next;
  logic [3:0]           os_reg, os_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [1:0]           samp_reg, samp_next;
  logic                 bit_reg, bit_next;

  // Control strobes from the FSM
  logic clear_div;
  logic tick;
  logic byte_done;
  logic frame_bad;

  // Output holding register
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 overrun_reg;
  logic                 frame_err_reg;

  // Two-flop synchronizer plus one history flop; all reset to line idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg      <= 2'b11;
      rx_s_prev_reg <= 1'b1;
    end else begin
      sync_reg      <= {sync_reg[0], rx};
      rx_s_prev_reg <= sync_reg[1];
    end
  end

  assign rx_s = sync_reg[1];
  assign fall = rx_s_prev_reg & ~rx_s;

  rs232_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_div),
    .tick  (tick)
  );

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      os_reg      <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      samp_reg    <= '0;
      bit_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      os_reg      <= os_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      samp_reg    <= samp_next;
      bit_reg     <= bit_next;
    end
  end

  // Next-state logic: bit timing, sampling, majority vote and framing.
  always_comb begin
    state_next   = state_reg;
    os_next      = os_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    samp_next    = samp_reg;
    bit_next     = bit_reg;
    clear_div    = 1'b0;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (fall) begin
          clear_div  = 1'b1;
          os_next    = '0;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          os_next = os_reg + 4'd1;
          if ((os_reg == OS_MID) && rx_s) begin
            // Line back high at mid start bit: glitch, not a frame.
            state_next = ST_IDLE;
          end else if (os_reg == OS_LAST) begin
            state_next   = ST_DATA;
            bit_idx_next = '0;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          os_next = os_reg + 4'd1;
          if (os_reg == OS_EARLY) samp_next[0] = rx_s;
          if (os_reg == OS_MID)   samp_next[1] = rx_s;
          if (os_reg == OS_LATE)  bit_next = majority3(samp_reg[0], samp_reg[1], rx_s);
          if (os_reg == OS_LAST) begin
            shift_next   = {bit_reg, shift_reg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx_reg + BW'(1);
            if (bit_idx_reg == BIT_LAST) state_next = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          os_next = os_reg + 4'd1;
          if (os_reg == OS_EARLY) samp_next[0] = rx_s;
          if (os_reg == OS_MID)   samp_next[1] = rx_s;
          if (os_reg == OS_LATE) begin
            // Decide at mid stop bit so the next start edge can follow
            // immediately after a single stop bit.
            if (majority3(samp_reg[0], samp_reg[1], rx_s)) begin
              byte_done  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              frame_bad  = 1'b1;
              state_next = ST_BREAK;
            end
          end
        end
      end

      ST_BREAK: begin
        // Line held low after a bad stop bit: wait for idle before
        // looking for the next start edge.
        if (rx_s) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Holding register with valid/ready handshake and sticky overrun. A byte
  // completing on the accepting edge replaces the old one without overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (byte_done) begin
      if (!valid_reg || bus.ready) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (valid_reg && bus.ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Single-cycle framing error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
    end
  end

  assign bus.data      = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
`timescale 1ns/1ps
// Directed bench for rs232_rx: drives 8N1 frames on rx at nominal and
// +/-3% line rates, checks decoded bytes, handshake, framing and overrun.
module tb_rs232_rx;

  localparam int BIT_CLKS = 432;  // 50 MHz / 115200 with 27-clock ticks
  localparam int FAST_CLKS = 419; // line at BAUD x 1.03
  localparam int SLOW_CLKS = 445; // line at BAUD x 0.97

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  always #5 clk = ~clk;

  rs232_rx_if bus ();

  rs232_rx #(
    .CLK_FREQ (50_000_000),
    .BAUD     (115200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state, sampled 1 ns after the falling edge, after the bench
  // has driven its inputs for that half cycle.
  logic [7:0] acc[$];
  int valid_cycles = 0;
  int fe_cycles    = 0;
  int fe_pulses    = 0;
  logic fe_prev    = 1'b0;

  always @(negedge clk) begin
    #1;
    if (bus.valid) valid_cycles++;
    if (bus.valid && bus.ready) acc.push_back(bus.data);
    if (bus.frame_err) fe_cycles++;
    if (bus.frame_err && !fe_prev) fe_pulses++;
    fe_prev = bus.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int clks, input logic stop);
    send_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) send_bit(b[i], clks);
    send_bit(stop, clks);
    $display("sent 0x%02h at %0d clk/bit stop=%0b", b, clks, stop);
  endtask

  function automatic logic [7:0] acc_at(input int idx);
    if (idx < acc.size()) return acc[idx];
    return 8'hxx;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int v0;
    int f0;
    int p0;

    bus.ready = 1'b1;
    reset = 1'b1;
    rx = 1'b1;
    idle(5);

    // Reset values
    check("rst_data",      bus.data,      8'h00);
    check("rst_valid",     bus.valid,     1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_overrun",   bus.overrun,   1'b0);
    check("rst_busy",      bus.busy,      1'b0);
    reset = 1'b0;
    idle(20);

    // Single byte, consumer always ready
    base = acc.size(); v0 = valid_cycles; f0 = fe_cycles;
    send_byte(8'hA5, BIT_CLKS, 1'b1);
    idle(100);
    check("a5_count",        acc.size() - base,  1);
    check("a5_data",         acc_at(base),       8'hA5);
    check("a5_data_reg",     bus.data,           8'hA5);
    check("a5_valid_cycles", valid_cycles - v0,  1);
    check("a5_frame_err",    fe_cycles - f0,     0);
    check("a5_overrun",      bus.overrun,        1'b0);

    // Back-to-back frames
    base = acc.size();
    send_byte(8'h00, BIT_CLKS, 1'b1);
    send_byte(8'hFF, BIT_CLKS, 1'b1);
    send_byte(8'h3C, BIT_CLKS, 1'b1);
    idle(100);
    check("b2b_count", acc.size() - base, 3);
    check("b2b_0",     acc_at(base),      8'h00);
    check("b2b_1",     acc_at(base + 1),  8'hFF);
    check("b2b_2",     acc_at(base + 2),  8'h3C);

    // Short low glitch is rejected
    v0 = valid_cycles;
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(20);
    check("glitch_busy_during", bus.busy, 1'b1);
    idle(400);
    check("glitch_busy_after", bus.busy,          1'b0);
    check("glitch_no_valid",   valid_cycles - v0, 0);
    base = acc.size();
    send_byte(8'h5A, BIT_CLKS, 1'b1);
    idle(100);
    check("after_glitch_data", acc_at(base), 8'h5A);

    // Bad stop bit followed by a held-low line
    v0 = valid_cycles; f0 = fe_cycles; p0 = fe_pulses;
    send_byte(8'h81, BIT_CLKS, 1'b0);
    idle(BIT_CLKS);
    check("brk_busy_mid", bus.busy, 1'b1);
    idle(BIT_CLKS);
    check("brk_fe_cycles", fe_cycles - f0,    1);
    check("brk_fe_pulses", fe_pulses - p0,    1);
    check("brk_no_valid",  valid_cycles - v0, 0);
    check("brk_busy_held", bus.busy,          1'b1);
    rx = 1'b1;
    idle(10);
    check("brk_busy_released", bus.busy, 1'b0);
    base = acc.size();
    send_byte(8'h81, BIT_CLKS, 1'b1);
    idle(100);
    check("after_brk_data", acc_at(base), 8'h81);

    // Overrun with consumer stalled
    bus.ready = 1'b0;
    base = acc.size();
    send_byte(8'h11, BIT_CLKS, 1'b1);
    idle(50);
    send_byte(8'h22, BIT_CLKS, 1'b1);
    idle(100);
    check("ovr_valid",   bus.valid,   1'b1);
    check("ovr_data",    bus.data,    8'h11);
    check("ovr_overrun", bus.overrun, 1'b1);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    idle(2);
    check("ovr_valid_after_ready", bus.valid,    1'b0);
    check("ovr_sticky",            bus.overrun,  1'b1);
    check("ovr_accepted",          acc_at(base), 8'h11);
    bus.ready = 1'b1;

    // Asynchronous reset midway through bit 4 of 0xC3
    v0 = valid_cycles;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i), BIT_CLKS);
    rx = 1'b0;  // bit 4 of 0xC3
    idle(BIT_CLKS / 2);
    #1 reset = 1'b1;
    #1;
    check("arst_data",      bus.data,      8'h00);
    check("arst_valid",     bus.valid,     1'b0);
    check("arst_overrun",   bus.overrun,   1'b0);
    check("arst_busy",      bus.busy,      1'b0);
    check("arst_frame_err", bus.frame_err, 1'b0);
    @(negedge clk);
    idle(BIT_CLKS / 2);
    send_bit(1'b0, BIT_CLKS);  // bit 5
    send_bit(1'b1, BIT_CLKS);  // bit 6
    send_bit(1'b1, BIT_CLKS);  // bit 7
    send_bit(1'b1, BIT_CLKS);  // stop
    reset = 1'b0;
    idle(50);
    check("arst_no_valid", valid_cycles - v0, 0);
    base = acc.size();
    send_byte(8'h7E, BIT_CLKS, 1'b1);
    idle(100);
    check("after_rst_data", acc_at(base), 8'h7E);

    // Line rate tolerance
    base = acc.size();
    send_byte(8'hA5, FAST_CLKS, 1'b1);
    idle(100);
    send_byte(8'hA5, SLOW_CLKS, 1'b1);
    idle(100);
    check("fast_data",   acc_at(base),      8'hA5);
    check("slow_data",   acc_at(base + 1),  8'hA5);
    check("tol_count",   acc.size() - base, 2);
    check("tol_overrun", bus.overrun,       1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
